// File: rtl/simon_pkg.sv
// Package: simon_pkg
// Purpose: Constants and types shared by the Simon game blocks (button_decoder
//          and simon_fsm): colour index width, number of buttons, decoder FSM
//          state encodings and a one-hot to index encoder.
// Ports:   none (package)
package simon_pkg;

  localparam int BTN_W   = 2;
  localparam int NUM_BTN = 4;

  // Colour indices, bit i of the button vector is colour i
  localparam logic [BTN_W-1:0] COLOUR_0 = 2'd0;
  localparam logic [BTN_W-1:0] COLOUR_1 = 2'd1;
  localparam logic [BTN_W-1:0] COLOUR_2 = 2'd2;
  localparam logic [BTN_W-1:0] COLOUR_3 = 2'd3;

  // Decoder presentation FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SHOW = 2'd2
  } dec_state_t;

  // Encodes a single-hot button vector into its colour index. Only meaningful
  // when exactly one bit is set; the caller filters out other cases.
  function automatic logic [BTN_W-1:0] btn_index(input logic [NUM_BTN-1:0] v);
    logic [BTN_W-1:0] idx;
    idx = COLOUR_0;
    if (v[1]) idx = COLOUR_1;
    if (v[2]) idx = COLOUR_2;
    if (v[3]) idx = COLOUR_3;
    return idx;
  endfunction

endpackage

// File: rtl/debounce_vec.sv
// Module: debounce_vec
// Purpose: Two-flop synchroniser per bit followed by a debouncer whose single
//          counter is shared by the whole vector: the synchronised vector must
//          be unchanged for DEB_CYCLES consecutive clocks before it is copied
//          to deb_v.
// Ports:
//   clk     in   1           system clock
//   reset   in   1           synchronous active-high reset
//   raw     in   W           asynchronous raw inputs
//   deb_v   out  W           debounced vector
//   deb_ok  out  1           high once deb_v holds a genuinely debounced value
//                            (as opposed to its reset value)
module debounce_vec
  import simon_pkg::*;
#(
  parameter int W          = NUM_BTN,
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb_v,
  output logic         deb_ok
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [W-1:0]     sync_1;
  logic [W-1:0]     sync_v;
  logic [W-1:0]     prev_v;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, change detector and saturating stability counter. Any
  // change restarts the count; once saturated the counter holds and deb_v
  // keeps tracking the (now stable) synchronised vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= '0;
      sync_v <= '0;
      prev_v <= '0;
      cnt    <= '0;
      deb_v  <= '0;
      deb_ok <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_v <= sync_1;
      prev_v <= sync_v;
      if (sync_v != prev_v) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        deb_v  <= sync_v;
        deb_ok <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_decoder.sv
// Module: button_decoder
// Purpose: Turns the four raw player buttons into clean single press events
//          for simon_fsm. Debounces the buttons, accepts only a press from an
//          all-released state with exactly one button, and presents it as
//          btn_valid/btn_val held across exactly one game-tick edge.
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous active-high reset
//   btn_raw    in   4  asynchronous raw buttons, bit i = colour i
//   tick_en    in   1  one-clk pulse marking each game-tick edge
//   btn_valid  out  1  press presented to simon_fsm
//   btn_val    out  2  colour index while btn_valid, 0 otherwise
//   overrun    out  1  one-clk pulse: press dropped, presentation busy
//   multi_rej  out  1  one-clk pulse: press with several buttons rejected
module button_decoder
  import simon_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               tick_en,
  output logic               btn_valid,
  output logic [BTN_W-1:0]   btn_val,
  output logic               overrun,
  output logic               multi_rej
);

  logic [NUM_BTN-1:0] deb_v;
  logic               deb_ok;
  logic [NUM_BTN-1:0] deb_prev;
  logic               armed;

  logic               rise;
  logic               evt;
  logic               multi;

  dec_state_t         state, state_n;
  logic [BTN_W-1:0]   btn_val_q, btn_val_q_n;
  logic               btn_valid_n;
  logic [BTN_W-1:0]   btn_val_n;
  logic               overrun_n;

  debounce_vec #(
    .W          (NUM_BTN),
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_raw),
    .deb_v  (deb_v),
    .deb_ok (deb_ok)
  );

  // The qualifier is only armed after an all-released vector has actually
  // been debounced. Without this, a button held through reset would look like
  // a fresh press once the reset value of deb_v is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev <= '0;
      armed    <= 1'b0;
    end else begin
      deb_prev <= deb_v;
      if (deb_ok && (deb_v == '0)) begin
        armed <= 1'b1;
      end
    end
  end

  // Press qualification: only a transition out of all-released counts.
  always_comb begin
    rise  = armed && (deb_prev == '0) && (deb_v != '0);
    evt   = rise && $onehot(deb_v);
    multi = rise && !$onehot(deb_v);
  end

  // Presentation FSM next state and next registered outputs. An event is
  // accepted only in IDLE; the cycle SHOW exits still counts as busy.
  always_comb begin
    state_n     = state;
    btn_val_q_n = btn_val_q;
    btn_valid_n = btn_valid;
    btn_val_n   = btn_val;
    overrun_n   = 1'b0;
    case (state)
      IDLE: begin
        btn_valid_n = 1'b0;
        btn_val_n   = '0;
        if (evt) begin
          btn_val_q_n = btn_index(deb_v);
          state_n     = PEND;
        end
      end
      PEND: begin
        overrun_n = evt;
        if (tick_en) begin
          state_n     = SHOW;
          btn_valid_n = 1'b1;
          btn_val_n   = btn_val_q;
        end
      end
      SHOW: begin
        overrun_n = evt;
        if (tick_en) begin
          state_n     = IDLE;
          btn_valid_n = 1'b0;
          btn_val_n   = '0;
        end
      end
      default: begin
        state_n     = IDLE;
        btn_valid_n = 1'b0;
        btn_val_n   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      btn_val_q <= '0;
      btn_valid <= 1'b0;
      btn_val   <= '0;
      overrun   <= 1'b0;
      multi_rej <= 1'b0;
    end else begin
      state     <= state_n;
      btn_val_q <= btn_val_q_n;
      btn_valid <= btn_valid_n;
      btn_val   <= btn_val_n;
      overrun   <= overrun_n;
      multi_rej <= multi;
    end
  end

endmodule

// File: tb/tb_button_decoder.sv
// Testbench: tb_button_decoder
// Purpose: Directed scenarios for button_decoder with DEB_CYCLES=4 and a
//          game tick every 20 clocks. Outputs are observed 1 time unit after
//          each rising clock edge and summarised per scenario.
module tb_button_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic       tick_en = 1'b0;
  logic       btn_valid;
  logic [1:0] btn_val;
  logic       overrun;
  logic       multi_rej;

  int vec_cnt = 0;
  int err_cnt = 0;

  int   valid_cnt;
  int   ov_cnt;
  int   mr_cnt;
  int   rises;
  int   edge_bad;
  int   idle_bad;
  logic [3:0] seen;
  logic prev_valid = 1'b0;
  int   tc = 0;

  button_decoder #(
    .DEB_CYCLES (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .tick_en   (tick_en),
    .btn_valid (btn_valid),
    .btn_val   (btn_val),
    .overrun   (overrun),
    .multi_rej (multi_rej)
  );

  always #5 clk = ~clk;

  // Game tick: one clock out of every 20, changed on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      tick_en = (tc == 19);
      tc = (tc + 1) % 20;
    end
  end

  task clear_stats;
    valid_cnt = 0;
    ov_cnt    = 0;
    mr_cnt    = 0;
    rises     = 0;
    edge_bad  = 0;
    idle_bad  = 0;
    seen      = 4'b0000;
  endtask

  // Observe n cycles and accumulate what the outputs did
  task sample(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (btn_valid) begin
        valid_cnt++;
        seen[btn_val] = 1'b1;
      end else if (btn_val != 2'd0) begin
        idle_bad++;
      end
      if (overrun)   ov_cnt++;
      if (multi_rej) mr_cnt++;
      if (btn_valid && !prev_valid) begin
        rises++;
        if (!tick_en) edge_bad++;
      end
      if (!btn_valid && prev_valid && !tick_en) edge_bad++;
      prev_valid = btn_valid;
    end
  endtask

  task drive(input logic [3:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  task test_reset;
    btn_raw = 4'b0000;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (btn_valid !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reset_valid: got %b, expected 0", btn_valid);
    end
    vec_cnt++;
    if (btn_val !== 2'd0) begin
      err_cnt++; $display("[TB] FAIL reset_val: got %0d, expected 0", btn_val);
    end
    vec_cnt++;
    if (overrun !== 1'b0 || multi_rej !== 1'b0) begin
      err_cnt++; $display("[TB] FAIL reset_pulses: got overrun=%b multi_rej=%b, expected 0/0", overrun, multi_rej);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_valid = 1'b0;
    clear_stats();
    sample(30);
    vec_cnt++;
    if (valid_cnt != 0 || ov_cnt != 0 || mr_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL reset_quiet: got valid=%0d ov=%0d mr=%0d, expected 0/0/0", valid_cnt, ov_cnt, mr_cnt);
    end
  endtask

  task test_single_press;
    clear_stats();
    drive(4'b0100);
    sample(30);
    drive(4'b0000);
    sample(70);
    vec_cnt++;
    if (valid_cnt != 20) begin
      err_cnt++; $display("[TB] FAIL t1_valid_cycles: got %0d, expected 20", valid_cnt);
    end
    vec_cnt++;
    if (seen !== 4'b0100) begin
      err_cnt++; $display("[TB] FAIL t1_values_shown: got %b, expected 0100", seen);
    end
    vec_cnt++;
    if (rises != 1 || edge_bad != 0) begin
      err_cnt++; $display("[TB] FAIL t1_tick_align: got rises=%0d off_tick=%0d, expected 1/0", rises, edge_bad);
    end
    vec_cnt++;
    if (idle_bad != 0 || ov_cnt != 0 || mr_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL t1_side: got idle_val=%0d ov=%0d mr=%0d, expected 0/0/0", idle_bad, ov_cnt, mr_cnt);
    end
  endtask

  task test_bounce;
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 4'b0001 : 4'b0000);
      sample(2);
    end
    drive(4'b0000);
    sample(60);
    vec_cnt++;
    if (valid_cnt != 0 || ov_cnt != 0 || mr_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL t2_bounce: got valid=%0d ov=%0d mr=%0d, expected 0/0/0", valid_cnt, ov_cnt, mr_cnt);
    end
  endtask

  task test_multi;
    clear_stats();
    drive(4'b0011);
    sample(40);
    drive(4'b0000);
    sample(20);
    vec_cnt++;
    if (mr_cnt != 1) begin
      err_cnt++; $display("[TB] FAIL t3_multi_rej: got %0d pulses, expected 1", mr_cnt);
    end
    vec_cnt++;
    if (valid_cnt != 0 || ov_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL t3_no_event: got valid=%0d ov=%0d, expected 0/0", valid_cnt, ov_cnt);
    end
  endtask

  task test_back_to_back;
    clear_stats();
    drive(4'b1000);
    sample(8);
    drive(4'b0000);
    sample(8);
    drive(4'b0010);
    sample(8);
    drive(4'b0000);
    sample(80);
    vec_cnt++;
    if (seen !== 4'b1000) begin
      err_cnt++; $display("[TB] FAIL t4_values_shown: got %b, expected 1000", seen);
    end
    vec_cnt++;
    if (ov_cnt != 1) begin
      err_cnt++; $display("[TB] FAIL t4_overrun: got %0d pulses, expected 1", ov_cnt);
    end
    vec_cnt++;
    if (valid_cnt != 20 || rises != 1 || edge_bad != 0) begin
      err_cnt++; $display("[TB] FAIL t4_presentation: got valid=%0d rises=%0d off_tick=%0d, expected 20/1/0", valid_cnt, rises, edge_bad);
    end
  endtask

  task test_rollover;
    clear_stats();
    drive(4'b0001);
    sample(20);
    drive(4'b0101);
    sample(20);
    drive(4'b0000);
    sample(60);
    vec_cnt++;
    if (rises != 1 || seen !== 4'b0001 || valid_cnt != 20) begin
      err_cnt++; $display("[TB] FAIL t5_single_event: got rises=%0d seen=%b valid=%0d, expected 1/0001/20", rises, seen, valid_cnt);
    end
    vec_cnt++;
    if (mr_cnt != 0 || ov_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL t5_no_pulses: got mr=%0d ov=%0d, expected 0/0", mr_cnt, ov_cnt);
    end
  endtask

  task test_reset_in_show;
    bit got_valid;
    clear_stats();
    drive(4'b0010);
    got_valid = 1'b0;
    for (int i = 0; i < 80 && !got_valid; i++) begin
      sample(1);
      if (btn_valid) got_valid = 1'b1;
    end
    vec_cnt++;
    if (!got_valid) begin
      err_cnt++; $display("[TB] FAIL t6_reach_show: got btn_valid=0 after 80 clks, expected 1");
    end
    sample(2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (btn_valid !== 1'b0 || btn_val !== 2'd0) begin
      err_cnt++; $display("[TB] FAIL t6_reset_outputs: got valid=%b val=%0d, expected 0/0", btn_valid, btn_val);
    end
    @(negedge clk);
    reset = 1'b0;
    prev_valid = 1'b0;
    clear_stats();
    sample(60);
    vec_cnt++;
    if (valid_cnt != 0 || ov_cnt != 0 || mr_cnt != 0) begin
      err_cnt++; $display("[TB] FAIL t6_held_after_reset: got valid=%0d ov=%0d mr=%0d, expected 0/0/0", valid_cnt, ov_cnt, mr_cnt);
    end
    drive(4'b0000);
    sample(20);
    clear_stats();
    drive(4'b0010);
    sample(20);
    drive(4'b0000);
    sample(60);
    vec_cnt++;
    if (rises != 1 || seen !== 4'b0010 || valid_cnt != 20) begin
      err_cnt++; $display("[TB] FAIL t6_repress: got rises=%0d seen=%b valid=%0d, expected 1/0010/20", rises, seen, valid_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_rollover();
    test_reset_in_show();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
